// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART receiver and transmitter.
//   - DEFAULT_OVERSAMPLE / DEFAULT_DATA_BITS : default frame geometry
//   - ST_IDLE .. ST_STOP : raw state encodings, so the transmitter can use the same values
//   - uart_state_t : enum built on those encodings, used by the FSMs
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync
// Two-flop synchronizer for asynchronous inputs. Reset drives both stages to
// RESET_VAL, so that an idle-high serial line does not look like an edge
// just after reset.
// Ports:
//   clk : destination clock
//   rst : synchronous, active-high reset
//   d   : asynchronous input
//   q   : synchronized output, two cycles behind d
module uart_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // The first stage may go metastable. The second stage gives it a full
  // cycle to settle before anything downstream uses the value.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// Oversampling 8N1 UART receiver (LSB first) with framing-error reporting.
// Ports:
//   baud_clk   : oversampling clock, OVERSAMPLE x bit rate
//   rst        : synchronous, active-high reset
//   rx_in      : asynchronous serial line, idle high
//   data_out   : last correctly framed byte
//   data_valid : one-cycle pulse, data_out updated
//   frame_err  : one-cycle pulse, stop bit sampled low
//   busy       : high whenever the FSM is outside IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev;
  uart_state_t          state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_done;

  uart_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (baud_clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // Frame FSM. Each counter phase ends on the cycle where tick reaches its
  // terminal value, and that cycle also samples the line: half a bit into the
  // start bit, then one full bit per data bit and for the stop bit.
  // After the stop sample the FSM stays in STOP for one extra cycle. That
  // cycle is the one in which the result pulse is visible, so busy covers it.
  // IDLE is entered right after the pulse, early enough to accept a start
  // edge that follows without any idle gap.
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_prev    <= 1'b1;
      stop_done  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_prev    <= rx_s;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          // Require a genuine high-to-low transition. A line stuck low after
          // a break therefore cannot retrigger a frame.
          if (!rx_s && rx_prev) begin
            state <= START;
            tick  <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (tick == TICK_HALF) begin
            tick    <= '0;
            bit_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        DATA: begin
          if (tick == TICK_LAST) begin
            tick  <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        STOP: begin
          if (stop_done) begin
            state     <= IDLE;
            busy      <= 1'b0;
            stop_done <= 1'b0;
          end else if (tick == TICK_LAST) begin
            tick      <= '0;
            stop_done <= 1'b1;
            if (rx_s) begin
              data_out   <= shift;
              data_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
